// File: rtl/maze_button_conditioner.sv
// Conditions four bouncy direction buttons into one-at-a-time move requests
// (sync, debounce, press detect, auto-repeat, valid/ready output slot).
module maze_button_conditioner #(
  parameter int DB_CYCLES    = 16,
  parameter int REPEAT_DELAY = 2000,
  parameter int REPEAT_RATE  = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_held,
  output logic       move_valid,
  output logic [1:0] move_dir,
  input  logic       move_ready
);

  localparam int DB_W    = $clog2(DB_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  localparam logic [0:0] RPT_WAIT_DELAY = 1'b0;
  localparam logic [0:0] RPT_WAIT_RATE  = 1'b1;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 4; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

  function automatic logic [1:0] lowest_index(input logic [3:0] v);
    logic [1:0] idx;
    casez (v)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  logic [3:0]      sync1_r;
  logic [3:0]      sync2_r;
  logic [DB_W-1:0] db_cnt_r      [4];
  logic [DB_W-1:0] db_cnt_next_s [4];
  logic [3:0]      held_r;
  logic [3:0]      held_next_s;
  logic [3:0]      rise_s;
  logic            change_s;

  logic [RPT_W-1:0] rpt_cnt_r;
  logic [RPT_W-1:0] rpt_cnt_next_s;
  logic [0:0]       rpt_state_r;
  logic [0:0]       rpt_state_next_s;
  logic             rpt_fire_s;
  logic             single_s;
  logic [3:0]       rpt_set_s;

  logic [3:0] pending_r;
  logic [3:0] pending_next_s;
  logic       valid_r;
  logic       valid_next_s;
  logic [1:0] dir_r;
  logic [1:0] dir_next_s;
  logic       free_s;

  // Two-flop synchroniser; the first stage feeds nothing but the second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: a level change is accepted after DB_CYCLES stable cycles.
  always_comb begin
    held_next_s = held_r;
    for (int i = 0; i < 4; i++) begin
      db_cnt_next_s[i] = '0;
      if (sync2_r[i] != held_r[i]) begin
        if (db_cnt_r[i] == DB_LAST) begin
          held_next_s[i]   = ~held_r[i];
          db_cnt_next_s[i] = '0;
        end else begin
          db_cnt_next_s[i] = db_cnt_r[i] + DB_W'(1);
        end
      end else begin
        db_cnt_next_s[i] = '0;
      end
    end
  end

  assign rise_s   = held_next_s & ~held_r;
  assign change_s = (held_next_s != held_r);

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      held_r <= held_next_s;
      for (int i = 0; i < 4; i++) begin
        db_cnt_r[i] <= db_cnt_next_s[i];
      end
    end
  end

  assign single_s = (popcount4(held_r) == 3'd1);

  // Auto-repeat timer: only a lone, unchanging held button keeps it running.
  always_comb begin
    rpt_cnt_next_s   = '0;
    rpt_state_next_s = RPT_WAIT_DELAY;
    rpt_fire_s       = 1'b0;
    if (change_s || !single_s) begin
      rpt_cnt_next_s   = '0;
      rpt_state_next_s = RPT_WAIT_DELAY;
    end else begin
      case (rpt_state_r)
        RPT_WAIT_DELAY: begin
          if (rpt_cnt_r == DELAY_LAST) begin
            rpt_fire_s       = 1'b1;
            rpt_state_next_s = RPT_WAIT_RATE;
          end else begin
            rpt_cnt_next_s   = rpt_cnt_r + RPT_W'(1);
            rpt_state_next_s = RPT_WAIT_DELAY;
          end
        end
        RPT_WAIT_RATE: begin
          if (rpt_cnt_r == RATE_LAST) begin
            rpt_fire_s       = 1'b1;
            rpt_state_next_s = RPT_WAIT_RATE;
          end else begin
            rpt_cnt_next_s   = rpt_cnt_r + RPT_W'(1);
            rpt_state_next_s = RPT_WAIT_RATE;
          end
        end
        default: begin
          rpt_cnt_next_s   = '0;
          rpt_state_next_s = RPT_WAIT_DELAY;
        end
      endcase
    end
  end

  assign rpt_set_s = rpt_fire_s ? held_r : 4'b0000;

  // Auto-repeat state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_r   <= '0;
      rpt_state_r <= RPT_WAIT_DELAY;
    end else begin
      rpt_cnt_r   <= rpt_cnt_next_s;
      rpt_state_r <= rpt_state_next_s;
    end
  end

  assign free_s = !valid_r || move_ready;

  // Output slot: lowest pending index wins; accept and reload share an edge.
  always_comb begin
    pending_next_s = pending_r;
    valid_next_s   = valid_r;
    dir_next_s     = dir_r;
    if (free_s) begin
      if (pending_r != 4'b0000) begin
        valid_next_s   = 1'b1;
        dir_next_s     = lowest_index(pending_r);
        pending_next_s = pending_r & ~(4'b0001 << lowest_index(pending_r));
      end else begin
        valid_next_s   = 1'b0;
      end
    end else begin
      valid_next_s = valid_r;
    end
    // New events are merged after the clear so a same-edge event survives.
    pending_next_s = pending_next_s | rise_s | rpt_set_s;
  end

  // Pending set and output slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 4'b0000;
      valid_r   <= 1'b0;
      dir_r     <= 2'd0;
    end else begin
      pending_r <= pending_next_s;
      valid_r   <= valid_next_s;
      dir_r     <= dir_next_s;
    end
  end

  assign btn_held   = held_r;
  assign move_valid = valid_r;
  assign move_dir   = dir_r;

endmodule

// File: tb/tb_maze_button_conditioner.sv
// Directed bench for maze_button_conditioner: a vector table for simple
// press sequences plus hand-written multi-cycle corner cases.
module tb_maze_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_held;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ready;

  int total;
  int bad;
  int cyc;
  logic [1:0] mv_dir [$];
  int         mv_cyc [$];

  typedef struct {
    logic [3:0] raw;
    logic       ready;
    int         n;
    logic [3:0] held;
    logic       valid;
    logic [1:0] dir;
  } vec_t;

  vec_t tbl [13];

  maze_button_conditioner #(
    .DB_CYCLES   (16),
    .REPEAT_DELAY(2000),
    .REPEAT_RATE (500)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_held  (btn_held),
    .move_valid(move_valid),
    .move_dir  (move_dir),
    .move_ready(move_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every handshake that the coming rising edge will complete.
  always @(negedge clk) begin
    if (rst_n && move_valid && move_ready) begin
      mv_dir.push_back(move_dir);
      mv_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int mv_at(input int i);
    if (i < mv_dir.size()) return int'(mv_dir[i]);
    return -1;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < mv_cyc.size()) return mv_cyc[i];
    return -100000;
  endfunction

  initial begin
    int glitch_err;
    int hold_err;
    total = 0;
    bad   = 0;
    cyc   = 0;

    // clean press of left, then up+... simultaneous down+right
    tbl[0]  = '{4'b0100, 1'b1, 17, 4'b0000, 1'b0, 2'd0};
    tbl[1]  = '{4'b0100, 1'b1,  1, 4'b0100, 1'b0, 2'd0};
    tbl[2]  = '{4'b0100, 1'b1,  1, 4'b0100, 1'b1, 2'd2};
    tbl[3]  = '{4'b0100, 1'b1,  1, 4'b0100, 1'b0, 2'd2};
    tbl[4]  = '{4'b0100, 1'b1, 20, 4'b0100, 1'b0, 2'd2};
    tbl[5]  = '{4'b0000, 1'b1, 17, 4'b0100, 1'b0, 2'd2};
    tbl[6]  = '{4'b0000, 1'b1,  1, 4'b0000, 1'b0, 2'd2};
    tbl[7]  = '{4'b0000, 1'b1,  5, 4'b0000, 1'b0, 2'd2};
    tbl[8]  = '{4'b1010, 1'b1, 18, 4'b1010, 1'b0, 2'd2};
    tbl[9]  = '{4'b1010, 1'b1,  1, 4'b1010, 1'b1, 2'd1};
    tbl[10] = '{4'b1010, 1'b1,  1, 4'b1010, 1'b1, 2'd3};
    tbl[11] = '{4'b1010, 1'b1,  1, 4'b1010, 1'b0, 2'd3};
    tbl[12] = '{4'b0000, 1'b1, 25, 4'b0000, 1'b0, 2'd3};

    rst_n      = 1'b0;
    btn_raw    = 4'b0000;
    move_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held", int'(btn_held), 0);
    chk("reset_valid", int'(move_valid), 0);
    chk("reset_dir", int'(move_dir), 0);
    rst_n = 1'b1;
    step();
    chk("idle_valid", int'(move_valid), 0);

    // table-driven press sequences
    for (int i = 0; i < 13; i++) begin
      btn_raw    = tbl[i].raw;
      move_ready = tbl[i].ready;
      repeat (tbl[i].n) step();
      chk($sformatf("tbl%0d_held", i), int'(btn_held), int'(tbl[i].held));
      chk($sformatf("tbl%0d_valid", i), int'(move_valid), int'(tbl[i].valid));
      chk($sformatf("tbl%0d_dir", i), int'(move_dir), int'(tbl[i].dir));
    end
    chk("tbl_move_count", mv_dir.size(), 3);
    chk("tbl_move0", mv_at(0), 2);
    chk("tbl_move1", mv_at(1), 1);
    chk("tbl_move2", mv_at(2), 3);
    chk("simul_back_to_back", cyc_at(2) - cyc_at(1), 1);

    // bounce on up: five 3-cycle glitches then a stable press
    mv_dir.delete();
    mv_cyc.delete();
    glitch_err = 0;
    for (int g = 0; g < 5; g++) begin
      btn_raw = 4'b0001;
      repeat (3) begin step(); if (btn_held != 4'b0000) glitch_err++; end
      btn_raw = 4'b0000;
      repeat (3) begin step(); if (btn_held != 4'b0000) glitch_err++; end
    end
    btn_raw = 4'b0001;
    repeat (17) begin step(); if (btn_held != 4'b0000) glitch_err++; end
    chk("bounce_no_glitch", glitch_err, 0);
    step();
    chk("bounce_held", int'(btn_held), 1);
    repeat (5) step();
    btn_raw = 4'b0000;
    repeat (25) step();
    chk("bounce_move_count", mv_dir.size(), 1);
    chk("bounce_move_dir", mv_at(0), 0);

    // back-pressure: two taps of up while ready=0
    mv_dir.delete();
    mv_cyc.delete();
    hold_err   = 0;
    move_ready = 1'b0;
    btn_raw    = 4'b0001;
    repeat (19) step();
    for (int ph = 0; ph < 4; ph++) begin
      btn_raw = (ph % 2 == 0) ? 4'b0001 : 4'b0000;
      if (ph == 2) btn_raw = 4'b0001;
      repeat ((ph == 0) ? 6 : 25) begin
        step();
        if (!(move_valid && move_dir == 2'd0)) hold_err++;
      end
      if (ph == 0) btn_raw = 4'b0000;
    end
    chk("bp_valid_held", hold_err, 0);
    chk("bp_no_accept", mv_dir.size(), 0);
    move_ready = 1'b1;
    repeat (5) step();
    chk("bp_move_count", mv_dir.size(), 2);
    chk("bp_move0", mv_at(0), 0);
    chk("bp_move1", mv_at(1), 0);
    chk("bp_drained", int'(move_valid), 0);

    // auto-repeat on right, stopped by a second button
    mv_dir.delete();
    mv_cyc.delete();
    btn_raw = 4'b1000;
    repeat (3120) step();
    btn_raw = 4'b1001;
    repeat (1000) step();
    btn_raw = 4'b0000;
    repeat (30) step();
    chk("rpt_move_count", mv_dir.size(), 5);
    for (int i = 0; i < 4; i++) chk($sformatf("rpt_dir%0d", i), mv_at(i), 3);
    chk("rpt_dir4", mv_at(4), 0);
    chk("rpt_first_gap", cyc_at(1) - cyc_at(0), 2000);
    chk("rpt_second_gap", cyc_at(2) - cyc_at(1), 500);
    chk("rpt_third_gap", cyc_at(3) - cyc_at(2), 500);

    // reset while a move is held and two more are pending
    mv_dir.delete();
    mv_cyc.delete();
    move_ready = 1'b0;
    btn_raw    = 4'b0111;
    repeat (19) step();
    chk("rst_pre_valid", int'(move_valid), 1);
    chk("rst_pre_dir", int'(move_dir), 0);
    btn_raw = 4'b0000;
    rst_n   = 1'b0;
    #1;
    chk("rst_held", int'(btn_held), 0);
    chk("rst_valid", int'(move_valid), 0);
    chk("rst_dir", int'(move_dir), 0);
    step();
    rst_n      = 1'b1;
    move_ready = 1'b1;
    repeat (60) step();
    chk("rst_no_move", mv_dir.size(), 0);
    chk("rst_idle_valid", int'(move_valid), 0);
    btn_raw = 4'b0010;
    repeat (25) step();
    btn_raw = 4'b0000;
    repeat (25) step();
    chk("rst_new_count", mv_dir.size(), 1);
    chk("rst_new_dir", mv_at(0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
